vram_scan_arbiter: RTL and testbench

- Owns the single-port video RAM that holds a 160x120, 3-bit-colour framebuffer. Each framebuffer pixel is shown as a 4x4 block on the 640x480 raster.
- Shares the RAM between two users:
  - Display scan-out: fixed-priority reads timed from the VGA sync counters.
  - Drawing/telemetry writer: req/ack handshake.
- Also runs a hardware clear sequencer.
- Sits between the sync generator (pixel_x, pixel_y, video_on) and the DAC pins.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/fb_addr_gen.sv | 60 ++++++
 rtl/vram_scan_arbiter.sv | 166 ++++++++++++++++
 tb/tb_vram_scan_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 640x480 VGA raster and the 160x120x3 framebuffer
// behind it, plus the arbiter state type and the row-base address helper.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACTIVE    = 640;
   localparam int V_ACTIVE    = 480;
   localparam int LINE_LAST   = 799;
   localparam int SCREEN_LAST = 524;
   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int FB_WORDS    = 19200;
   localparam int ADDR_W      = 15;
   localparam int COLOR_W     = 3;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_t;

   // row*160 as two shifts and an add, so no multiplier is inferred
   function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] row);
      logic [ADDR_W-1:0] w_row;
      w_row = {{(ADDR_W-8){1'b0}}, row};
      return (w_row << 7) + (w_row << 5);
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Combinational display-slot decoder. A slot is every 4th pixel clock; it
// fetches the framebuffer word that will be shown four clocks later, so the
// target column is one block ahead and, in the last block of a line, the
// target row is taken from the next raster line (wrapping the frame).
// Ports:
//   i_pixel_x    [9:0]  current raster column
//   i_pixel_y    [9:0]  current raster row
//   o_slot_valid        this cycle is a display read slot inside the buffer
//   o_addr       [14:0] framebuffer word address for the slot
// -----------------------------------------------------------------------------
module fb_addr_gen #(
   parameter int FB_W        = vga_pkg::FB_W,
   parameter int FB_H        = vga_pkg::FB_H,
   parameter int LINE_LAST   = vga_pkg::LINE_LAST,
   parameter int SCREEN_LAST = vga_pkg::SCREEN_LAST
) (
   input  logic [9:0]                 i_pixel_x,
   input  logic [9:0]                 i_pixel_y,
   output logic                       o_slot_valid,
   output logic [vga_pkg::ADDR_W-1:0] o_addr
);
   import vga_pkg::*;

   localparam logic [7:0] COL_LAST = 8'((LINE_LAST + 1) / 4 - 1);
   localparam logic [9:0] X_WRAP   = 10'(LINE_LAST - 3);
   localparam logic [9:0] Y_LAST   = 10'(SCREEN_LAST);
   localparam logic [7:0] W_LIM    = 8'(FB_W);
   localparam logic [7:0] H_LIM    = 8'(FB_H);

   logic [7:0] w_xq;
   logic [7:0] w_tx;
   logic [7:0] w_ty;
   logic       w_next_line;

   // (pixel_x+4) mod 800, divided by 4, is simply the next block index mod 200
   assign w_xq        = i_pixel_x[9:2];
   assign w_tx        = (w_xq == COL_LAST) ? 8'd0 : w_xq + 8'd1;
   assign w_next_line = (i_pixel_x >= X_WRAP);

   // target row: current line, or the following line (frame wrap) in the last block
   always_comb begin
      w_ty = i_pixel_y[9:2];
      if (w_next_line) begin
         if (i_pixel_y == Y_LAST) begin
            w_ty = 8'd0;
         end else begin
            // (y+1)/4 only steps up when y is the last line of a block
            w_ty = i_pixel_y[9:2] + {7'd0, &i_pixel_y[1:0]};
         end
      end else begin
         w_ty = i_pixel_y[9:2];
      end
   end

   assign o_slot_valid = (i_pixel_x[1:0] == 2'b00) && (w_tx < W_LIM) && (w_ty < H_LIM);
   assign o_addr       = row_base(w_ty) + {{(ADDR_W-8){1'b0}}, w_tx};

endmodule

// File: rtl/vram_scan_arbiter.sv
// -----------------------------------------------------------------------------
// vram_scan_arbiter
// Owns the single-port video RAM. Display scan-out reads have fixed priority on
// their slots; a req/ack writer and a full-buffer clear sequencer share every
// other ("free") cycle. Also drives the DAC colour from the fetched words.
// Ports:
//   clock25, reset (async, active-low)
//   pixel_x/pixel_y/video_on     from the sync generator
//   wr_req/wr_addr/wr_data/wr_ack writer handshake (ack = write this cycle)
//   clear_req/clear_busy/clear_done clear sequencer control/status
//   mem_addr/mem_we/mem_wdata/mem_rdata RAM port (read data 1 cycle later)
//   rgb                          pixel colour, 0 outside the active area
// -----------------------------------------------------------------------------
module vram_scan_arbiter #(
   parameter int         FB_W           = vga_pkg::FB_W,
   parameter int         FB_H           = vga_pkg::FB_H,
   parameter int         LINE_LAST      = vga_pkg::LINE_LAST,
   parameter int         SCREEN_LAST    = vga_pkg::SCREEN_LAST,
   parameter int         WR_VBLANK_ONLY = 0,
   parameter logic [2:0] CLEAR_COLOR    = 3'b000
) (
   input  logic                        clock25,
   input  logic                        reset,
   input  logic [9:0]                  pixel_x,
   input  logic [9:0]                  pixel_y,
   input  logic                        video_on,
   input  logic                        wr_req,
   input  logic [vga_pkg::ADDR_W-1:0]  wr_addr,
   input  logic [vga_pkg::COLOR_W-1:0] wr_data,
   output logic                        wr_ack,
   input  logic                        clear_req,
   output logic                        clear_busy,
   output logic                        clear_done,
   output logic [vga_pkg::ADDR_W-1:0]  mem_addr,
   output logic                        mem_we,
   output logic [vga_pkg::COLOR_W-1:0] mem_wdata,
   input  logic [vga_pkg::COLOR_W-1:0] mem_rdata,
   output logic [vga_pkg::COLOR_W-1:0] rgb
);
   import vga_pkg::*;

   localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(FB_W * FB_H - 1);
   localparam logic [9:0]        V_START   = 10'(V_ACTIVE);

   logic                 w_slot_valid;
   logic [ADDR_W-1:0]    w_disp_addr;
   logic                 w_free;
   arb_state_t           r_state;
   arb_state_t           w_state_nxt;
   logic [ADDR_W-1:0]    r_clr_addr;
   logic [ADDR_W-1:0]    w_clr_addr_nxt;
   logic                 r_clear_done;
   logic                 w_clear_done_nxt;
   logic                 r_rd_pend;
   logic [COLOR_W-1:0]   r_rd_q;
   logic [COLOR_W-1:0]   r_hold_q;
   logic                 w_we;
   logic                 w_ack;
   logic [ADDR_W-1:0]    w_addr;
   logic [COLOR_W-1:0]   w_wdata;

   fb_addr_gen #(
      .FB_W        (FB_W),
      .FB_H        (FB_H),
      .LINE_LAST   (LINE_LAST),
      .SCREEN_LAST (SCREEN_LAST)
   ) u_addr_gen (
      .i_pixel_x    (pixel_x),
      .i_pixel_y    (pixel_y),
      .o_slot_valid (w_slot_valid),
      .o_addr       (w_disp_addr)
   );

   // writer/clear may only use cycles the display does not own
   assign w_free = !w_slot_valid && ((WR_VBLANK_ONLY == 0) || (pixel_y >= V_START));

   // arbiter next-state and RAM port decision
   always_comb begin
      w_state_nxt      = r_state;
      w_clr_addr_nxt   = r_clr_addr;
      w_clear_done_nxt = 1'b0;
      w_we             = 1'b0;
      w_ack            = 1'b0;
      w_addr           = w_disp_addr;
      w_wdata          = {COLOR_W{1'b0}};
      case (r_state)
         ST_IDLE: begin
            if (w_free && wr_req) begin
               w_we    = 1'b1;
               w_ack   = 1'b1;
               w_addr  = wr_addr;
               w_wdata = wr_data;
            end else begin
               w_we    = 1'b0;
               w_ack   = 1'b0;
            end
            if (clear_req) begin
               w_state_nxt    = ST_CLEAR;
               w_clr_addr_nxt = {ADDR_W{1'b0}};
            end else begin
               w_state_nxt    = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (w_free) begin
               w_we    = 1'b1;
               w_addr  = r_clr_addr;
               w_wdata = CLEAR_COLOR;
               if (r_clr_addr == CLR_LAST) begin
                  w_state_nxt      = ST_IDLE;
                  w_clr_addr_nxt   = {ADDR_W{1'b0}};
                  w_clear_done_nxt = 1'b1;
               end else begin
                  w_clr_addr_nxt   = r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end else begin
               w_we = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // arbiter state, clear pointer and completion pulse
   always_ff @(posedge clock25 or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_clr_addr   <= {ADDR_W{1'b0}};
         r_clear_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clr_addr   <= w_clr_addr_nxt;
         r_clear_done <= w_clear_done_nxt;
      end
   end

   // scan-out pipeline: capture read data, then hold it for the 4-pixel block
   always_ff @(posedge clock25 or negedge reset) begin
      if (!reset) begin
         r_rd_pend <= 1'b0;
         r_rd_q    <= {COLOR_W{1'b0}};
         r_hold_q  <= {COLOR_W{1'b0}};
      end else begin
         r_rd_pend <= w_slot_valid;
         if (r_rd_pend) begin
            r_rd_q <= mem_rdata;
         end
         // block boundary: the word fetched 3 clocks ago becomes visible next clock
         if (pixel_x[1:0] == 2'b11) begin
            r_hold_q <= r_rd_q;
         end
      end
   end

   // write strobes are forced off for as long as reset is held
   assign mem_we     = w_we & reset;
   assign wr_ack     = w_ack & reset;
   assign mem_addr   = w_addr;
   assign mem_wdata  = w_wdata;
   assign clear_busy = (r_state == ST_CLEAR);
   assign clear_done = r_clear_done;
   assign rgb        = video_on ? r_hold_q : {COLOR_W{1'b0}};

endmodule

// File: tb/tb_vram_scan_arbiter.sv
`timescale 1ns/1ps
module tb_vram_scan_arbiter;

   logic        clock25 = 1'b0;
   logic        reset;
   logic [9:0]  pixel_x, pixel_y;
   logic        video_on;
   logic        wr_req, b_wr_req;
   logic [14:0] wr_addr, b_wr_addr;
   logic [2:0]  wr_data, b_wr_data;
   logic        clear_req;
   logic        wr_ack, clear_busy, clear_done, mem_we;
   logic [14:0] mem_addr;
   logic [2:0]  mem_wdata, rgb;
   logic        b_wr_ack, b_clear_busy, b_clear_done, b_mem_we;
   logic [14:0] b_mem_addr;
   logic [2:0]  b_mem_wdata, b_rgb;

   logic [2:0]  ram [0:32767];
   logic [2:0]  r_rdata;
   logic        do_preload;

   int n_vec = 0;
   int n_err = 0;
   int cx = 0;
   int cy = 0;
   int exp_q[$];

   typedef struct {
      int x; int y; bit req; int addr; int data;
      int e_addr; bit e_we; bit e_ack;
   } vec_t;
   vec_t vt[14];

   always #20 clock25 = ~clock25;

   vram_scan_arbiter dut (
      .clock25(clock25), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on(video_on), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .clear_req(clear_req), .clear_busy(clear_busy),
      .clear_done(clear_done), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(r_rdata), .rgb(rgb)
   );

   vram_scan_arbiter #(.WR_VBLANK_ONLY(1)) dut_vb (
      .clock25(clock25), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on(video_on), .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .wr_ack(b_wr_ack), .clear_req(1'b0), .clear_busy(b_clear_busy),
      .clear_done(b_clear_done), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
      .mem_wdata(b_mem_wdata), .mem_rdata(3'b000), .rgb(b_rgb)
   );

   // synchronous single-port RAM model, 1-cycle read latency
   always @(posedge clock25) begin
      if (do_preload) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 3'(i);
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         r_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d)", name, act, exp, cx, cy);
      end
   endtask

   task automatic drive_pos();
      pixel_x  = 10'(cx);
      pixel_y  = 10'(cy);
      video_on = (cx < 640) && (cy < 480);
   endtask

   task automatic step();
      @(posedge clock25); #1;
      if (cx == 799) begin
         cx = 0;
         cy = (cy == 524) ? 0 : cy + 1;
      end else begin
         cx = cx + 1;
      end
      drive_pos();
   endtask

   task automatic jump(input int x, input int y);
      @(posedge clock25); #1;
      cx = x; cy = y;
      drive_pos();
   endtask

   task automatic sample();
      @(negedge clock25);
   endtask

   // independent display-slot model straight from the raster arithmetic
   function automatic bit model_slot(input int x, input int y);
      int tx, line, ty;
      tx   = ((x + 4) % 800) / 4;
      line = (x >= 796) ? ((y == 524) ? 0 : y + 1) : y;
      ty   = line / 4;
      return (x % 4 == 0) && (tx < 160) && (ty < 120);
   endfunction

   function automatic int exp_rgb(input int x, input int y);
      if (x < 640 && y < 480) return ((y / 4) * 160 + x / 4) % 8;
      return 0;
   endfunction

   initial begin
      int e, n, wcnt, bad, acks, dones, busy_hi;
      reset = 1'b0; do_preload = 1'b1;
      wr_req = 1'b1; wr_addr = 15'd5; wr_data = 3'd3; clear_req = 1'b0;
      b_wr_req = 1'b0; b_wr_addr = 15'd0; b_wr_data = 3'd0;
      cx = 1; cy = 0; drive_pos();
      @(posedge clock25); #1 do_preload = 1'b0;
      sample();
      chk("rst_mem_we", mem_we, 0);
      chk("rst_wr_ack", wr_ack, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_clear_done", clear_done, 0);
      chk("rst_rgb", rgb, 0);
      wr_req = 1'b0;
      reset = 1'b1;

      // raster readout, line 0 (pipeline primed from the end of line 524)
      jump(790, 524);
      for (int i = 0; i < 810; i++) begin
         if (cy == 0) exp_q.push_back(exp_rgb(cx, cy));
         sample();
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rgb_y0", rgb, e);
         end
         step();
      end
      // raster readout, last visible line 479
      jump(780, 478);
      for (int i = 0; i < 820; i++) begin
         if (cy == 479) exp_q.push_back(exp_rgb(cx, cy));
         sample();
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rgb_y479", rgb, e);
         end
         step();
      end

      // single-cycle arbitration vectors (all from IDLE)
      vt[0]  = '{796, 524, 1'b0, 0,     0, 0,     1'b0, 1'b0};
      vt[1]  = '{796, 3,   1'b0, 0,     0, 160,   1'b0, 1'b0};
      vt[2]  = '{0,   0,   1'b1, 1234,  5, 1,     1'b0, 1'b0};
      vt[3]  = '{5,   10,  1'b1, 1234,  5, 1234,  1'b1, 1'b1};
      vt[4]  = '{4,   10,  1'b1, 1234,  5, 322,   1'b0, 1'b0};
      vt[5]  = '{636, 10,  1'b1, 77,    2, 77,    1'b1, 1'b1};
      vt[6]  = '{796, 479, 1'b1, 19300, 4, 19300, 1'b1, 1'b1};
      vt[7]  = '{632, 479, 1'b1, 19300, 4, 19199, 1'b0, 1'b0};
      vt[8]  = '{799, 524, 1'b1, 300,   3, 300,   1'b1, 1'b1};
      vt[9]  = '{100, 200, 1'b1, 300,   3, 8026,  1'b0, 1'b0};
      vt[10] = '{796, 523, 1'b1, 42,    6, 42,    1'b1, 1'b1};
      vt[11] = '{0,   480, 1'b1, 43,    7, 43,    1'b1, 1'b1};
      vt[12] = '{792, 2,   1'b1, 44,    1, 44,    1'b1, 1'b1};
      vt[13] = '{796, 478, 1'b1, 45,    2, 19040, 1'b0, 1'b0};
      for (int i = 0; i < 14; i++) begin
         jump(vt[i].x, vt[i].y);
         wr_req  = vt[i].req;
         wr_addr = 15'(vt[i].addr);
         wr_data = 3'(vt[i].data);
         sample();
         chk("vec_addr", mem_addr, vt[i].e_addr);
         chk("vec_we", mem_we, vt[i].e_we);
         chk("vec_ack", wr_ack, vt[i].e_ack);
         if (vt[i].e_we) chk("vec_wdata", mem_wdata, vt[i].data);
      end
      wr_req = 1'b0;

      // writer held from the slot at x=4: ack only at x=5
      jump(3, 10);
      sample();
      step();
      wr_req = 1'b1; wr_addr = 15'd500; wr_data = 3'd6;
      sample();
      chk("arb_x4_ack", wr_ack, 0);
      chk("arb_x4_we", mem_we, 0);
      chk("arb_x4_addr", mem_addr, 322);
      step();
      sample();
      chk("arb_x5_ack", wr_ack, 1);
      chk("arb_x5_we", mem_we, 1);
      chk("arb_x5_addr", mem_addr, 500);
      chk("arb_x5_wdata", mem_wdata, 6);
      step();
      wr_req = 1'b0;
      sample();
      chk("arb_x6_we", mem_we, 0);
      step();
      sample();
      chk("arb_ram500", ram[500], 6);

      // vblank-only instance: no ack on visible lines, ack at y=480 x=0
      jump(0, 100);
      b_wr_req = 1'b1; b_wr_addr = 15'd9; b_wr_data = 3'd1;
      n = 0;
      for (int i = 0; i < 800; i++) begin
         sample();
         if (b_wr_ack) n++;
         step();
      end
      jump(0, 479);
      for (int i = 0; i < 800; i++) begin
         sample();
         if (b_wr_ack || b_mem_we) n++;
         step();
      end
      chk("vb_no_ack_visible", n, 0);
      sample();
      chk("vb_ack_480", b_wr_ack, 1);
      chk("vb_we_480", b_mem_we, 1);
      chk("vb_addr_480", b_mem_addr, 9);
      chk("vb_wdata_480", b_mem_wdata, 1);
      chk("vb_clear_idle", b_clear_busy | b_clear_done, 0);
      chk("vb_rgb", b_rgb, 0);
      b_wr_req = 1'b0;

      // full clear with a writer knocking throughout
      jump(0, 0);
      clear_req = 1'b1;
      sample();
      wcnt = 0; bad = 0; acks = 0; dones = 0;
      for (int i = 0; i < 40000; i++) begin
         step();
         if (i == 0) begin
            clear_req = 1'b0; wr_req = 1'b1; wr_addr = 15'd20000; wr_data = 3'd7;
         end
         sample();
         if (i == 0) chk("clear_busy_start", clear_busy, 1);
         if (clear_busy && mem_we) begin
            if (mem_wdata != 3'd0 || int'(mem_addr) != wcnt || model_slot(cx, cy)) bad++;
            wcnt++;
         end
         if (clear_busy && wr_ack) acks++;
         if (clear_done) begin
            dones++;
            chk("busy_at_done", clear_busy, 0);
            wr_req = 1'b0;
            break;
         end
      end
      wr_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         sample();
         if (clear_done) dones++;
      end
      chk("clear_writes", wcnt, 19200);
      chk("clear_bad_writes", bad, 0);
      chk("clear_wr_acks", acks, 0);
      chk("clear_done_pulses", dones, 1);
      chk("clear_busy_after", clear_busy, 0);
      n = 0;
      for (int i = 0; i < 19200; i++) if (ram[i] != 3'd0) n++;
      chk("clear_ram_nonzero", n, 0);

      // reset after 5000 clear writes
      jump(0, 0);
      clear_req = 1'b1;
      sample();
      wcnt = 0;
      for (int i = 0; i < 20000 && wcnt < 5000; i++) begin
         step();
         if (i == 0) begin
            clear_req = 1'b0; wr_req = 1'b1; wr_addr = 15'd20000; wr_data = 3'd7;
         end
         sample();
         if (clear_busy && mem_we) wcnt++;
      end
      chk("rst_mid_writes", wcnt, 5000);
      reset = 1'b0;
      #1;
      chk("rst_mid_we", mem_we, 0);
      chk("rst_mid_busy", clear_busy, 0);
      chk("rst_mid_ack", wr_ack, 0);
      wr_req = 1'b0;
      step(); step();
      sample();
      reset = 1'b1;
      dones = 0; busy_hi = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         sample();
         if (clear_done) dones++;
         if (clear_busy) busy_hi++;
      end
      chk("rst_mid_no_done", dones, 0);
      chk("rst_mid_no_busy", busy_hi, 0);
      jump(1, 0);
      wr_req = 1'b1; wr_addr = 15'd77; wr_data = 3'd5;
      sample();
      chk("rst_mid_idle_ack", wr_ack, 1);
      wr_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
